lc3x_muldiv: RTL and testbench

Iterative multi-cycle multiply/divide unit for the LC3X extensions (MULT, DIV). Receives requests from the datapath control FSM and returns a registered result with a single-cycle response pulse, which takes the wide combinational multiplier and divider off the single-cycle ALU path. The control FSM stalls on ready/resp, and the result is muxed into the register-file writeback.

---
 rtl/lc3x_muldiv.sv | 130 +++++++++++++
 tb/tb_lc3x_muldiv.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc3x_muldiv.sv
// Iterative multiply/divide unit for the LC3X MULT and DIV extensions.
// Shift-add multiply and restoring divide, one bit per cycle, registered result with a one-cycle resp pulse.
module lc3x_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             resp,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic             op_q;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   acc;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             dz;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] lo_nxt;

  // Control: ready only in IDLE, resp only in DONE.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    resp      = 1'b0;
    dz        = op && (b == '0);
    last      = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) state_nxt = dz ? DONE : CALC;
      end
      CALC: if (last) state_nxt = DONE;
      DONE: begin
        resp      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = ready && req;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // acc is the high product half for multiply and the remainder for divide;
  // lo holds the multiplier (consumed LSB first) or the dividend (consumed MSB
  // first, replaced by quotient bits).
  always_comb begin
    mul_sum = acc + (lo[0] ? {1'b0, operand} : {(WIDTH + 1){1'b0}});
    shifted = {acc[WIDTH-1:0], lo[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, operand};
    if (op_q) begin
      if (!trial[WIDTH+1]) begin
        acc_nxt = trial[WIDTH:0];
        lo_nxt  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted;
        lo_nxt  = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = {1'b0, mul_sum[WIDTH:1]};
      lo_nxt  = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= 1'b0;
      operand   <= '0;
      lo        <= '0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= op;
          acc  <= '0;
          cnt  <= '0;
          if (op) begin
            lo      <= a;
            operand <= b;
          end else begin
            lo      <= b;
            operand <= a;
          end
          if (dz) begin
            result    <= '1;
            result_hi <= a;
            div_zero  <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            result    <= lo_nxt;
            result_hi <= acc_nxt[WIDTH-1:0];
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3x_muldiv.sv
// Scoreboard bench for lc3x_muldiv: stimulus pushes model results, a negedge monitor
// checks ready/resp timing, result values and that results hold between operations.
module tb_lc3x_muldiv;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         resp;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         div_zero;

  typedef struct {
    int unsigned  accCyc;
    int unsigned  respCyc;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  int unsigned  cyc = 0;
  int           nChecks = 0;
  int           nFails = 0;
  logic [W-1:0] heldRes;
  logic [W-1:0] heldHi;
  logic         heldDz;
  logic         inReset;

  lc3x_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .a(a), .b(b),
    .ready(ready), .resp(resp), .result(result), .result_hi(result_hi),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic plus the documented latency.
  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int unsigned c);
    exp_t             e;
    logic [2*W-1:0]   prod;
    e.accCyc = c;
    if (!o) begin
      prod      = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      e.res     = prod[W-1:0];
      e.hi      = prod[2*W-1:W];
      e.dz      = 1'b0;
      e.respCyc = c + W + 1;
    end else if (y == 0) begin
      e.res     = '1;
      e.hi      = x;
      e.dz      = 1'b1;
      e.respCyc = c + 1;
    end else begin
      e.res     = x / y;
      e.hi      = x % y;
      e.dz      = 1'b0;
      e.respCyc = c + W + 1;
    end
    return e;
  endfunction

  // Monitor: busy from the cycle after accept through the resp cycle; results hold otherwise.
  always @(negedge clk) begin
    logic expReady;
    logic expResp;
    exp_t e;
    if (!inReset) begin
      if (sb.size() == 0) begin
        expReady = 1'b1;
        expResp  = 1'b0;
      end else begin
        expReady = (cyc <= sb[0].accCyc);
        expResp  = (cyc == sb[0].respCyc);
      end
      checkOutput("ready", {31'b0, ready}, {31'b0, expReady});
      checkOutput("resp", {31'b0, resp}, {31'b0, expResp});
      if (expResp) begin
        e = sb.pop_front();
        checkOutput("result", {16'b0, result}, {16'b0, e.res});
        checkOutput("result_hi", {16'b0, result_hi}, {16'b0, e.hi});
        checkOutput("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
        heldRes = e.res;
        heldHi  = e.hi;
        heldDz  = e.dz;
      end else begin
        checkOutput("held_result", {16'b0, result}, {16'b0, heldRes});
        checkOutput("held_result_hi", {16'b0, result_hi}, {16'b0, heldHi});
        checkOutput("held_div_zero", {31'b0, div_zero}, {31'b0, heldDz});
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (!ready) checkOutput("idle_timeout", {31'b0, ready}, 32'd1);
  endtask

  task automatic doReset();
    inReset = 1'b1;
    reset   = 1'b1;
    sb.delete();
    @(posedge clk); #2;
    reset   = 1'b0;
    heldRes = '0;
    heldHi  = '0;
    heldDz  = 1'b0;
    inReset = 1'b0;
  endtask

  task automatic applyStimulus(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    waitIdle();
    req = 1'b1;
    op  = o;
    a   = x;
    b   = y;
    sb.push_back(model(o, x, y, cyc));
    @(posedge clk); #2;
    req = 1'b0;
    op  = 1'($urandom);
    a   = W'($urandom);
    b   = W'($urandom);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int unsigned nextAcc;
    int          accepts;
    exp_t        e;
    logic [W-1:0] ra, rb;
    inReset = 1'b1;
    reset   = 1'b1;
    req     = 1'b0;
    op      = 1'b0;
    a       = '0;
    b       = '0;
    heldRes = '0;
    heldHi  = '0;
    heldDz  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    doReset();
    @(posedge clk); #2;

    applyStimulus(1'b0, 16'h0007, 16'h0006);
    applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
    applyStimulus(1'b0, 16'h8000, 16'h0002);
    applyStimulus(1'b1, 16'd100,  16'd7);
    applyStimulus(1'b1, 16'h0003, 16'h0009);
    applyStimulus(1'b1, 16'hFFFF, 16'h0001);
    applyStimulus(1'b1, 16'h0005, 16'h0000);
    applyStimulus(1'b0, 16'h0003, 16'h0004);

    // req held high with operands changing every cycle; the bench decides acceptance cycles itself
    waitIdle();
    nextAcc = cyc;
    accepts = 0;
    for (int i = 0; i < 60 && accepts < 2; i++) begin
      req = 1'b1;
      op  = 1'($urandom);
      a   = W'($urandom);
      b   = W'($urandom);
      if (cyc == nextAcc) begin
        e = model(op, a, b, cyc);
        sb.push_back(e);
        nextAcc = cyc + (e.dz ? 2 : W + 2);
        accepts++;
      end
      @(posedge clk); #2;
    end
    req = 1'b0;

    // reset in cycle 8 of a divide aborts it without a response
    applyStimulus(1'b1, 16'h1234, 16'h0056);
    repeat (7) begin @(posedge clk); #2; end
    doReset();
    applyStimulus(1'b0, 16'h0007, 16'h0006);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = '1;
      applyStimulus(1'($urandom), ra, rb);
    end

    for (int n = 0; n < 200 && sb.size() != 0; n++) begin
      @(posedge clk); #2;
    end
    repeat (3) begin @(posedge clk); #2; end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
